// File: rtl/lif_param_loader.sv
// Loads a five-byte LIF neuron configuration frame into shadow registers and
// commits the whole set atomically, rejecting frames whose threshold is zero.
module lif_param_loader #(
    parameter int NUM_BYTES = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_en,
    input  logic       data_valid,
    input  logic [7:0] data_in,
    output logic [2:0] weight_a,
    output logic [7:0] leak_rate_1,
    output logic [7:0] leak_rate_2,
    output logic [7:0] threshold,
    output logic [3:0] leak_cycles_1,
    output logic [3:0] leak_cycles_2,
    output logic       params_ready,
    output logic       busy,
    output logic       load_done,
    output logic       cfg_error
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_BYTES - 1);

    state_t     state_r;
    state_t     state_s;
    logic [2:0] cnt_r;
    logic [2:0] sh_weight_r;
    logic [7:0] sh_leak1_r;
    logic [7:0] sh_leak2_r;
    logic [7:0] sh_thr_r;
    logic [3:0] sh_cyc1_r;
    logic [3:0] sh_cyc2_r;
    logic       accept_s;
    logic       abort_s;
    logic       commit_ok_s;
    logic       commit_bad_s;

    // Next-state selection and frame event decode
    always_comb begin
        state_s      = state_r;
        accept_s     = 1'b0;
        abort_s      = 1'b0;
        commit_ok_s  = 1'b0;
        commit_bad_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load_en) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!load_en) begin
                    abort_s = 1'b1;
                    state_s = ST_IDLE;
                end else if (data_valid) begin
                    accept_s = 1'b1;
                    if (cnt_r == LAST_IDX) begin
                        state_s = ST_COMMIT;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_COMMIT: begin
                state_s = ST_WAIT_REL;
                if (sh_thr_r != 8'd0) begin
                    commit_ok_s = 1'b1;
                end else begin
                    commit_bad_s = 1'b1;
                end
            end
            ST_WAIT_REL: begin
                if (!load_en) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_REL;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register, byte counter and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 3'd0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            state_r   <= state_s;
            busy      <= (state_s == ST_LOAD) || (state_s == ST_COMMIT);
            load_done <= commit_ok_s;
            cfg_error <= commit_bad_s;
            if (state_r == ST_IDLE) begin
                cnt_r <= 3'd0;
            end else if (accept_s && (cnt_r != LAST_IDX)) begin
                cnt_r <= cnt_r + 3'd1;
            end
        end
    end

    // Shadow capture; an aborted frame leaves nothing behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_weight_r <= 3'd0;
            sh_leak1_r  <= 8'd0;
            sh_leak2_r  <= 8'd0;
            sh_thr_r    <= 8'd0;
            sh_cyc1_r   <= 4'd0;
            sh_cyc2_r   <= 4'd0;
        end else if (accept_s) begin
            case (cnt_r)
                3'd0:    sh_weight_r <= data_in[2:0];
                3'd1:    sh_leak1_r  <= data_in;
                3'd2:    sh_leak2_r  <= data_in;
                3'd3:    sh_thr_r    <= data_in;
                3'd4: begin
                    sh_cyc1_r <= data_in[7:4];
                    sh_cyc2_r <= data_in[3:0];
                end
                default: sh_weight_r <= sh_weight_r;
            endcase
        end else if (abort_s) begin
            sh_weight_r <= 3'd0;
            sh_leak1_r  <= 8'd0;
            sh_leak2_r  <= 8'd0;
            sh_thr_r    <= 8'd0;
            sh_cyc1_r   <= 4'd0;
            sh_cyc2_r   <= 4'd0;
        end
    end

    // Committed parameter set, updated only by an accepted frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_a      <= 3'd0;
            leak_rate_1   <= 8'd0;
            leak_rate_2   <= 8'd0;
            threshold     <= 8'd0;
            leak_cycles_1 <= 4'd0;
            leak_cycles_2 <= 4'd0;
            params_ready  <= 1'b0;
        end else if (commit_ok_s) begin
            weight_a      <= sh_weight_r;
            leak_rate_1   <= sh_leak1_r;
            leak_rate_2   <= sh_leak2_r;
            threshold     <= sh_thr_r;
            leak_cycles_1 <= sh_cyc1_r;
            leak_cycles_2 <= sh_cyc2_r;
            params_ready  <= 1'b1;
        end
    end

endmodule
